dmem_access_unit: RTL
=====================

DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: maximum WAIT cycles before an access is abandoned; legal range 2..65535.
REQ-002 clk  in  1  sole clock; all state updates on posedge.
REQ-003 rst  in  1  reset; synchronous and active-high.
REQ-004 req_valid  in  1  pipeline MEM-stage access request.
REQ-005 req_ready  out  1  unit can accept a request; high exactly when state is IDLE.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_funct3  in  3  RV32I width code: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, right-aligned.
REQ-010 rsp_valid  out  1  one-cycle completion pulse.
REQ-011 rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-012 rsp_err  out  1  misaligned, illegal funct3 or timeout; valid with rsp_valid.
REQ-013 mem_addr  out  32  word-aligned address, bits [1:0] = 0.
REQ-014 mem_read / mem_write  out  1 each  memory strobes; never both high.
REQ-015 mem_wmask  out  4  byte enables; 0 on loads.
REQ-016 mem_wdata  out  32  lane-replicated store data.
REQ-017 mem_rdata  in  32, mem_resp  in  1  memory return data and completion.

Function
REQ-018 FSM states SHALL be IDLE, WAIT and DONE; all mem_* and rsp_* outputs SHALL be registered.
REQ-019 Acceptance SHALL occur on a posedge with req_valid && req_ready && !rst; all request fields SHALL be latched at that edge.
REQ-020 Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) or illegal funct3 SHALL go IDLE->DONE with no strobe, rsp_err=1, rsp_rdata=0.
REQ-021 A legal request SHALL go IDLE->WAIT, asserting mem_read or mem_write plus mem_addr={addr[31:2],2'b00}, mem_wmask and mem_wdata from the next cycle.
REQ-022 Store mask/data SHALL be: SB 4'b0001<<addr[1:0] with {4{wdata[7:0]}}; SH 4'b0011<<{addr[1],1'b0} with {2{wdata[15:0]}}; SW 4'b1111 with wdata.
REQ-023 In WAIT, strobes, address, mask and data SHALL hold stable until the posedge where mem_resp=1.
REQ-024 On that edge, strobes SHALL drop to 0, the state SHALL go to DONE, and load data SHALL be captured.
REQ-025 Load extraction SHALL select byte addr[1:0] or half addr[1], sign-extending for LB/LH and zero-extending for LBU/LHU.
REQ-026 DONE SHALL last exactly one cycle with rsp_valid=1, then return to IDLE; rsp_valid SHALL be 0 in all other states.
REQ-027 mem_resp SHALL be ignored in IDLE and DONE, absorbing the trailing response the memory returns for the strobe sampled at the completion edge.
REQ-028 A WAIT cycle counter SHALL be 0 on WAIT entry; if it reaches TIMEOUT_CYCLES-1 with mem_resp=0, the unit SHALL drop strobes and go to DONE with rsp_err=1 and rsp_rdata=0.
REQ-029 mem_resp=1 in the final counted cycle SHALL complete normally, not time out.
REQ-030 Minimum accept-to-rsp_valid latency SHALL be 3 cycles for memory accesses and 1 cycle for rejected requests.
REQ-031 Back-to-back throughput SHALL be one access per 3 cycles minimum, since req_ready is low in WAIT and DONE.

Reset
REQ-032 With rst high at a posedge, the state SHALL become IDLE, the counter 0, and mem_read, mem_write, rsp_valid and rsp_err 0.
REQ-033 Reset SHALL also clear mem_addr, mem_wmask, mem_wdata and rsp_rdata to 0.
REQ-034 Reset mid-WAIT SHALL abort the access without a response; stray mem_resp afterwards SHALL be ignored.
REQ-035 No request SHALL be accepted on an edge where rst=1.

Verification
REQ-036 LB addr 0x0000_0103, memory word 0x80FF_7F01 -> mem_addr 0x100; rsp_rdata 0xFFFF_FF80 three cycles after accept; no second rsp_valid.
REQ-037 SH addr 0x0000_0202, wdata 0x1234_ABCD -> mem_write=1, mem_wmask 4'b1100, mem_wdata 0xABCD_ABCD; rsp_valid with rsp_rdata 0.
REQ-038 LW addr 0x0000_0006 -> no strobe; the next cycle rsp_valid=1, rsp_err=1, rsp_rdata 0.
REQ-039 TIMEOUT_CYCLES=4, mem_resp tied 0 -> mem_read high exactly 4 cycles, then rsp_err=1; next request accepted.
REQ-040 rst pulsed during WAIT, then mem_resp=1 -> strobes 0 after reset edge, no rsp_valid, req_ready=1.
REQ-041 LHU addr 0x0000_0012, word 0xBEEF_0000 -> rsp_rdata 0x0000_BEEF; LH of same -> 0xFFFF_BEEF.

Source files
------------

// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - RV32I data-memory access unit with alignment, lane steering and timeout
module dmem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [15:0] cnt_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;

  logic        legal_d;
  logic        aligned_d;
  logic [3:0]  wmask_d;
  logic [31:0] wdata_d;
  logic [7:0]  byte_d;
  logic [15:0] half_d;
  logic [31:0] load_d;

  assign req_ready = (state_q == IDLE);

  // Decode the incoming request: legality, alignment and store lane steering.
  always_comb begin
    legal_d   = 1'b0;
    aligned_d = 1'b0;
    wmask_d   = 4'b0000;
    wdata_d   = 32'h0;
    case (req_funct3)
      3'b000:         begin legal_d = 1'b1;    aligned_d = 1'b1; end
      3'b001:         begin legal_d = 1'b1;    aligned_d = ~req_addr[0]; end
      3'b010:         begin legal_d = 1'b1;    aligned_d = (req_addr[1:0] == 2'b00); end
      3'b100:         begin legal_d = ~req_we; aligned_d = 1'b1; end
      3'b101:         begin legal_d = ~req_we; aligned_d = ~req_addr[0]; end
      default:        begin legal_d = 1'b0;    aligned_d = 1'b0; end
    endcase
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          wmask_d = 4'b0001 << req_addr[1:0];
          wdata_d = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          wmask_d = 4'b0011 << {req_addr[1], 1'b0};
          wdata_d = {2{req_wdata[15:0]}};
        end
        default: begin
          wmask_d = 4'b1111;
          wdata_d = req_wdata;
        end
      endcase
    end
  end

  // Pick the addressed byte/half out of the returned word and extend it.
  always_comb begin
    byte_d = mem_rdata[7:0];
    case (off_q)
      2'd0:    byte_d = mem_rdata[7:0];
      2'd1:    byte_d = mem_rdata[15:8];
      2'd2:    byte_d = mem_rdata[23:16];
      default: byte_d = mem_rdata[31:24];
    endcase
    half_d = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_d = {{24{byte_d[7]}}, byte_d};
      3'b001:  load_d = {{16{half_d[15]}}, half_d};
      3'b100:  load_d = {24'h0, byte_d};
      3'b101:  load_d = {16'h0, half_d};
      default: load_d = mem_rdata;
    endcase
    if (we_q) begin
      load_d = 32'h0;
    end
  end

  // Access FSM; every memory-side and response output is a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 16'h0;
      we_q      <= 1'b0;
      funct3_q  <= 3'b000;
      off_q     <= 2'b00;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wmask <= 4'b0000;
      mem_wdata <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'h0;
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            off_q    <= req_addr[1:0];
            cnt_q    <= 16'h0;
            if (legal_d && aligned_d) begin
              state_q   <= WAIT;
              mem_read  <= ~req_we;
              mem_write <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wmask <= wmask_d;
              mem_wdata <= wdata_d;
            end else begin
              // Rejected requests never touch memory and answer next cycle.
              state_q   <= DONE;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (mem_resp) begin
            state_q   <= DONE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= load_d;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= DONE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'h0;
          end else begin
            cnt_q <= cnt_q + 16'h1;
          end
        end
        DONE: begin
          // The trailing mem_resp for the last sampled strobe lands here and is dropped.
          state_q   <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'h0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
